tictactoe_display: RTL and testbench
====================================

# tictactoe_display

Downstream consumer of `tictactoe`. Watches its move outputs (`xoroout`, `rowout`, `colout`, `err`, `win`) and keeps a shadow 3x3 board. Multiplexes the board onto a row-scanned LED matrix. Drives blinking win/draw and error indicators.

## Interface
- `SCAN_DIV`, default 4: clock cycles each LED row stays selected (≥1).
- `BLINK_DIV`, default 8: clock cycles per blink half-period (≥1).
- `ERR_HOLD`, default 16: clock cycles `err_led` stays lit after an error (≥1).
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `xoroout`  in  2: mover from `tictactoe`; 01=X, 10=O, 00/11=no move.
- `rowout`  in  2: move row, 0..2; 3 = invalid.
- `colout`  in  2: move column, 0..2; 3 = invalid.
- `err`  in  1: illegal-move flag from `tictactoe`.
- `win`  in  2: 00=in play, 01=X won, 10=O won, 11=draw.
- `led_row`  out  3: one-hot row select for the row being scanned.
- `led_x`  out  3: X cells of the scanned row; bit c = column c.
- `led_o`  out  3: O cells of the scanned row; bit c = column c.
- `win_led`  out  1: game-over indicator (blinks).
- `err_led`  out  1: error indicator.
- `move_count`  out  4: number of occupied cells, 0..9.

## Operation
- Board: 9 cells × 2 bits (00 empty, 01 X, 10 O).
- Capture condition, all required on the same cycle:
  - `xoroout` ∈ {01,10}
  - `rowout` ≤ 2 and `colout` ≤ 2
  - `err` = 0 and `win` = 00
  - target cell empty
- On capture, write `xoroout` into cell [row][col] and increment `move_count`.
- Holding the same move on the inputs over many cycles therefore writes only once; the cell is no longer empty after the first write.
- Non-empty target, or out-of-range row/col: no write, no error; the inputs are ignored.
- `err` = 1: no write. Load the error counter with `ERR_HOLD`. Re-assertion while counting reloads it.
- `err_led` = 1 while the error counter ≠ 0. The counter decrements each cycle.
- `move_count` saturates at 9.
- Scan FSM has states ROW0 → ROW1 → ROW2 → ROW0.
  - A divider counts 0..`SCAN_DIV`-1.
  - When the divider wraps, the FSM advances.
  - `led_row` = 001 / 010 / 100 respectively.
- `led_x[c]` = (cell[r][c] == 01) & vis; `led_o[c]` = (cell[r][c] == 10) & vis, where r is the current scan row.
- Blink phase toggles every `BLINK_DIV` cycles. It runs freely only while `win` ≠ 00 and is held at 1 when `win` = 00.
- vis:
  - `win` = 00: vis = 1.
  - `win` = 01: vis = 1 for O cells; vis = blink phase for X cells.
  - `win` = 10: vis = 1 for X cells; vis = blink phase for O cells.
  - `win` = 11: vis = blink phase for all cells.
- `win_led` = (`win` ≠ 00) & blink phase.
- `win` returning to 00 without `reset` unfreezes capture. The board is not cleared. The blink phase returns to 1 on the next edge.

## Timing
- Reset values: board all empty; `move_count` = 0; scan state ROW0 with divider 0, so `led_row` = 001; `led_x` = `led_o` = 000; error counter 0, so `err_led` = 0; blink phase 1 with blink counter 0; `win_led` = 0.
- Reset mid-game clears everything on that edge. The inputs on a reset cycle are not captured.
- Capture latency: inputs sampled at edge E. The cell and `move_count` are valid after E.
- LED outputs are combinational from registered state (scan, board, blink) plus `win`. A move captured at E is visible after E if its row is being scanned; otherwise within 3·`SCAN_DIV` cycles.
- `err` sampled at E sets `err_led` = 1 after E. `err_led` falls after edge E+`ERR_HOLD` if `err` is not re-asserted.
- Scan period is 3·`SCAN_DIV` cycles. Each row is selected for exactly `SCAN_DIV` consecutive cycles.
- `err` and a valid move on the same cycle: `err` wins and the move is not captured.
- `win` ≠ 00 on the same cycle as a valid move: the move is not captured.

## Test plan
- Reset, then observe 24 cycles with defaults: `led_row` sequence is 001×4, 010×4, 100×4, repeating; `led_x` = `led_o` = 0; `move_count` = 0; `err_led` = `win_led` = 0.
- Hold `xoroout`=01, `rowout`=1, `colout`=2 for 5 cycles: `move_count` = 1, not 5. While `led_row` = 010, `led_x` = 100 and `led_o` = 000.
- O at (1,2) after X there: rejected, `move_count` unchanged. `xoroout`=10, `rowout`=3, `colout`=0: ignored. `err`=1 together with a valid O move at (0,0): not captured, `err_led` = 1 for 16 cycles.
- X at (0,0), (0,1), (0,2) with O at (1,0), (1,1), then `win`=01: `win_led` and the X LEDs toggle every 8 cycles while the O LEDs stay lit. A new move at (2,2) is not captured.
- Fill all 9 cells, then `win`=11: `move_count` = 9 and all LEDs blink together. Asserting `reset` mid-blink clears the board, sets `led_row` = 001, and `move_count` = 0 on the next cycle.

Source files
------------

// File: rtl/tictactoe_display_if.sv
// Move/status bus published by the tictactoe game engine and watched by its display.
interface tictactoe_display_if;
    logic [1:0] xoroout;
    logic [1:0] rowout;
    logic [1:0] colout;
    logic       err;
    logic [1:0] win;

    modport master (output xoroout, rowout, colout, err, win);
    modport slave  (input  xoroout, rowout, colout, err, win);
endinterface

// File: rtl/tictactoe_display.sv
// Shadow 3x3 board built from tictactoe moves, row-scanned onto an LED matrix
// with blinking game-over and held error indicators.
//
//   state | meaning
//   ROW0  | row 0 selected, led_row = 001
//   ROW1  | row 1 selected, led_row = 010
//   ROW2  | row 2 selected, led_row = 100
module tictactoe_display #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8,
    parameter int ERR_HOLD  = 16
) (
    input  logic                clk,
    input  logic                reset,
    tictactoe_display_if.slave  mv_i,
    output logic [2:0]          led_row,
    output logic [2:0]          led_x,
    output logic [2:0]          led_o,
    output logic                win_led,
    output logic                err_led,
    output logic [3:0]          move_count
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int EW = $clog2(ERR_HOLD + 1);

    typedef enum logic [1:0] {ROW0, ROW1, ROW2} scan_e;

    scan_e          state_q, state_d;
    logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]     board_q [9];
    logic [3:0]     move_cnt_q;
    logic [EW-1:0]  err_cnt_q;
    logic [BW-1:0]  blink_cnt_q;
    logic           blink_q;

    logic           mover_ok;
    logic           in_range;
    logic [3:0]     cell_idx;
    logic           capture;
    logic           game_over;

    assign game_over = (mv_i.win != 2'b00);
    assign mover_ok  = (mv_i.xoroout == 2'b01) || (mv_i.xoroout == 2'b10);
    assign in_range  = (mv_i.rowout != 2'd3) && (mv_i.colout != 2'd3);
    assign cell_idx  = ({2'b00, mv_i.rowout} * 4'd3) + {2'b00, mv_i.colout};
    // cell_idx only indexes the board once the range check has passed
    assign capture   = mover_ok && in_range && !mv_i.err && !game_over &&
                       (board_q[cell_idx] == 2'b00);

    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q + 1'b1;
        led_row    = 3'b001;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            case (state_q)
                ROW0:    state_d = ROW1;
                ROW1:    state_d = ROW2;
                default: state_d = ROW0;
            endcase
        end
        case (state_q)
            ROW1:    led_row = 3'b010;
            ROW2:    led_row = 3'b100;
            default: led_row = 3'b001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ROW0;
            scan_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
            move_cnt_q <= '0;
        end else if (capture) begin
            board_q[cell_idx] <= mv_i.xoroout;
            if (move_cnt_q != 4'd9) move_cnt_q <= move_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)              err_cnt_q <= '0;
        else if (mv_i.err)      err_cnt_q <= EW'(ERR_HOLD);
        else if (err_cnt_q != 0) err_cnt_q <= err_cnt_q - 1'b1;
    end

    // Phase parks at 1 during play so the board is steady when a game ends.
    always_ff @(posedge clk) begin
        if (reset || !game_over) begin
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_q     <= ~blink_q;
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    logic vis_x, vis_o;
    logic [1:0] row_cells [3];

    always_comb begin
        vis_x = 1'b1;
        vis_o = 1'b1;
        case (mv_i.win)
            2'b01:   vis_x = blink_q;
            2'b10:   vis_o = blink_q;
            2'b11: begin
                vis_x = blink_q;
                vis_o = blink_q;
            end
            default: ;
        endcase
        for (int c = 0; c < 3; c++) row_cells[c] = board_q[c];
        case (state_q)
            ROW1:    for (int c = 0; c < 3; c++) row_cells[c] = board_q[3 + c];
            ROW2:    for (int c = 0; c < 3; c++) row_cells[c] = board_q[6 + c];
            default: ;
        endcase
        led_x = 3'b000;
        led_o = 3'b000;
        for (int c = 0; c < 3; c++) begin
            led_x[c] = (row_cells[c] == 2'b01) && vis_x;
            led_o[c] = (row_cells[c] == 2'b10) && vis_o;
        end
    end

    assign win_led    = game_over && blink_q;
    assign err_led    = (err_cnt_q != '0);
    assign move_count = move_cnt_q;

endmodule

// File: tb/tb_tictactoe_display.sv
// Randomised and directed bench for tictactoe_display against a cycle-count board model.
module tb_tictactoe_display;

    localparam int SCAN  = 4;
    localparam int BLINK = 8;
    localparam int EHOLD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] led_row, led_x, led_o;
    logic       win_led, err_led;
    logic [3:0] move_count;

    tictactoe_display_if bus ();

    tictactoe_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ERR_HOLD(EHOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .mv_i       (bus.slave),
        .led_row    (led_row),
        .led_x      (led_x),
        .led_o      (led_o),
        .win_led    (win_led),
        .err_led    (err_led),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: board contents plus elapsed-time counters.
    int  m_board [9];
    int  m_count;
    int  m_t;        // edges since reset
    int  m_errleft;  // edges of err_led remaining
    int  m_blink_n;  // consecutive edges with game over
    bit  started = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) m_board[i] = 0;
            m_count = 0; m_t = 0; m_errleft = 0; m_blink_n = 0;
            started = 1;
        end else if (started) begin
            int idx;
            m_t++;
            if (bus.err) m_errleft = EHOLD;
            else if (m_errleft > 0) m_errleft--;
            if (bus.win != 2'b00) m_blink_n++;
            else m_blink_n = 0;
            idx = int'(bus.rowout) * 3 + int'(bus.colout);
            if ((bus.xoroout == 2'b01 || bus.xoroout == 2'b10) && bus.rowout < 3 &&
                bus.colout < 3 && !bus.err && bus.win == 2'b00 && m_board[idx] == 0) begin
                m_board[idx] = int'(bus.xoroout);
                if (m_count < 9) m_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int r, ex, eo;
            bit phase, vx, vo;
            r     = (m_t / SCAN) % 3;
            phase = ((m_blink_n / BLINK) % 2) == 0;
            vx    = (bus.win == 2'b00 || bus.win == 2'b10) ? 1'b1 : phase;
            vo    = (bus.win == 2'b00 || bus.win == 2'b01) ? 1'b1 : phase;
            ex = 0; eo = 0;
            for (int c = 0; c < 3; c++) begin
                if (m_board[r*3+c] == 1 && vx) ex |= (1 << c);
                if (m_board[r*3+c] == 2 && vo) eo |= (1 << c);
            end
            chk("led_row", int'(led_row), 1 << r);
            chk("led_x", int'(led_x), ex);
            chk("led_o", int'(led_o), eo);
            chk("move_count", int'(move_count), m_count);
            chk("err_led", int'(err_led), int'(m_errleft != 0));
            chk("win_led", int'(win_led), int'(bus.win != 2'b00 && phase));
        end
    end

    task automatic drive(input logic [1:0] x, input logic [1:0] r, input logic [1:0] c,
                         input logic e, input logic [1:0] w);
        bus.xoroout = x; bus.rowout = r; bus.colout = c; bus.err = e; bus.win = w;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic move(input logic [1:0] x, input logic [1:0] r, input logic [1:0] c);
        drive(x, r, c, 1'b0, 2'b00);
        tick(1);
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b00);
        tick(1);
    endtask

    task automatic do_reset();
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b00);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        int win_hold;
        reset = 1'b1;
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b00);
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("lit_reset_row", int'(led_row), 1);
        chk("lit_reset_cnt", int'(move_count), 0);
        tick(24);

        // held move writes once
        drive(2'b01, 2'd1, 2'd2, 1'b0, 2'b00);
        tick(5);
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("lit_hold_once", int'(move_count), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (led_row == 3'b010) begin
                chk("lit_row1_x", int'(led_x), 3'b100);
                chk("lit_row1_o", int'(led_o), 0);
            end
        end
        tick(1);

        move(2'b10, 2'd1, 2'd2);
        move(2'b10, 2'd3, 2'd0);
        @(negedge clk);
        chk("lit_rejects", int'(move_count), 1);
        tick(1);
        drive(2'b10, 2'd0, 2'd0, 1'b1, 2'b00);
        tick(1);
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk("lit_err_on", int'(err_led), 1);
        chk("lit_err_nocap", int'(move_count), 1);
        tick(15);
        @(negedge clk);
        chk("lit_err_last", int'(err_led), 1);
        tick(1);
        @(negedge clk);
        chk("lit_err_off", int'(err_led), 0);
        tick(1);

        // X wins on row 0
        do_reset();
        move(2'b01, 2'd0, 2'd0);
        move(2'b10, 2'd1, 2'd0);
        move(2'b01, 2'd0, 2'd1);
        move(2'b10, 2'd1, 2'd1);
        move(2'b01, 2'd0, 2'd2);
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b01);
        @(negedge clk);
        chk("lit_win_led_on", int'(win_led), 1);
        tick(8);
        @(negedge clk);
        chk("lit_win_led_off", int'(win_led), 0);
        drive(2'b10, 2'd2, 2'd2, 1'b0, 2'b01);
        tick(3);
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b01);
        tick(40);
        @(negedge clk);
        chk("lit_frozen", int'(move_count), 5);
        tick(1);

        // full board, draw, reset mid-blink
        do_reset();
        for (int i = 0; i < 9; i++)
            move((i % 2 == 0) ? 2'b01 : 2'b10, 2'(i / 3), 2'(i % 3));
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b11);
        tick(20);
        @(negedge clk);
        chk("lit_full", int'(move_count), 9);
        tick(1);
        do_reset();
        @(negedge clk);
        chk("lit_rst_cnt", int'(move_count), 0);
        chk("lit_rst_row", int'(led_row), 1);
        chk("lit_rst_x", int'(led_x), 0);
        tick(1);

        // random traffic
        win_hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) win_hold = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            if ($urandom_range(0, 29) == 0) win_hold = 0;
            reset = ($urandom_range(0, 249) == 0);
            drive(2'($urandom), 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 19) == 0), 2'(win_hold));
            tick(1);
        end
        reset = 1'b0;
        drive(2'b00, 2'd0, 2'd0, 1'b0, 2'b00);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
